// File: rtl/gtech_pser4.sv
// rtl/gtech_pser4.sv - 4-bit parallel-in serial-out shifter with load handshake and done pulse
// Optional: define GTECH_PSER4_PARITY_EN to append an even parity bit as a 5th frame bit.
module gtech_pser4 (
  input  logic CP,
  input  logic CD,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic LDV,
  output logic LDR,
  input  logic SE,
  output logic SO,
  output logic SOV,
  output logic DONE
);

`ifdef GTECH_PSER4_PARITY_EN
  localparam int FW = 5;
`else
  localparam int FW = 4;
`endif

  // Index of the final frame bit; a shift edge at this index ends the frame.
  localparam logic [2:0] LAST = 3'(FW - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [2:0]    bcnt;
  logic [2:0]    next_bcnt;
  logic [FW-1:0] sreg;
  logic [FW-1:0] next_sreg;
  logic          done_q;
  logic          next_done;
  logic [FW-1:0] load_word;
  logic [7:0]    sreg_ext;

  // Word captured on a load edge; D0 sits in bit 0 so it is the first bit out.
`ifdef GTECH_PSER4_PARITY_EN
  assign load_word = {D0 ^ D1 ^ D2 ^ D3, D3, D2, D1, D0};
`else
  assign load_word = {D3, D2, D1, D0};
`endif

  // Zero-extended copy so the 3-bit counter can index the register directly.
  assign sreg_ext = 8'(sreg);

  // State, counter, data register and done flag; CD clears everything without a clock.
  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      state  <= IDLE;
      bcnt   <= 3'd0;
      sreg   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      bcnt   <= next_bcnt;
      sreg   <= next_sreg;
      done_q <= next_done;
    end
  end

  // Next-state logic: load from IDLE, advance on SE in SHIFT, return to IDLE after the last bit.
  always_comb begin
    next_state = state;
    next_bcnt  = bcnt;
    next_sreg  = sreg;
    next_done  = 1'b0;
    case (state)
      IDLE: begin
        // SE is ignored here; only a load moves the block forward.
        if (LDV) begin
          next_state = SHIFT;
          next_bcnt  = 3'd0;
          next_sreg  = load_word;
        end
      end
      SHIFT: begin
        // LDV is ignored while a frame is in flight.
        if (SE) begin
          if (bcnt == LAST) begin
            next_state = IDLE;
            next_bcnt  = 3'd0;
            next_done  = 1'b1;
          end else begin
            next_bcnt = bcnt + 3'd1;
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_bcnt  = 3'd0;
      end
    endcase
  end

  // Outputs are decoded from registered state only; the line idles high.
  always_comb begin
    LDR  = 1'b1;
    SOV  = 1'b0;
    SO   = 1'b1;
    DONE = done_q;
    if (state == SHIFT) begin
      LDR = 1'b0;
      SOV = 1'b1;
      SO  = sreg_ext[bcnt];
    end
  end

endmodule

// File: tb/tb_gtech_pser4.sv
// tb/tb_gtech_pser4.sv - table-driven self-checking bench for gtech_pser4 (default 4-bit frame build)
module tb_gtech_pser4;

  logic CP = 1'b0;
  logic CD = 1'b1;
  logic D0 = 1'b0;
  logic D1 = 1'b0;
  logic D2 = 1'b0;
  logic D3 = 1'b0;
  logic LDV = 1'b0;
  logic SE = 1'b0;
  logic LDR;
  logic SO;
  logic SOV;
  logic DONE;
  logic clk_run = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  gtech_pser4 dut (
    .CP   (CP),
    .CD   (CD),
    .D0   (D0),
    .D1   (D1),
    .D2   (D2),
    .D3   (D3),
    .LDV  (LDV),
    .LDR  (LDR),
    .SE   (SE),
    .SO   (SO),
    .SOV  (SOV),
    .DONE (DONE)
  );

  // Clock only runs once clk_run is set, so reset can be checked with CP stopped.
  always #5 CP = clk_run ? ~CP : CP;

  // exp = {LDR, SO, SOV, DONE} after the edge; d = {D3, D2, D1, D0}
  typedef struct {
    logic       cd;
    logic       ldv;
    logic [3:0] d;
    logic       se;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic cd, input logic ldv, input logic [3:0] d,
                             input logic se, input logic [3:0] exp, input string name);
    vec_t r;
    r.cd = cd; r.ldv = ldv; r.d = d; r.se = se; r.exp = exp; r.name = name;
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {LDR, SO, SOV, DONE};
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {LDR,SO,SOV,DONE}=%b expected %b", name, got, exp);
  endtask

  task automatic drive(input logic cd, input logic ldv, input logic [3:0] d, input logic se);
    CD = cd; LDV = ldv; SE = se;
    {D3, D2, D1, D0} = d;
  endtask

  initial begin
    // Word 1011 shifted with SE high; D changed after load must not matter
    vq.push_back(v(0, 1, 4'b1011, 1, 4'b0110, "r27_b0"));
    vq.push_back(v(0, 0, 4'b0000, 1, 4'b0110, "r27_b1"));
    vq.push_back(v(0, 0, 4'b0000, 1, 4'b0010, "r27_b2"));
    vq.push_back(v(0, 0, 4'b0000, 1, 4'b0110, "r27_b3"));
    vq.push_back(v(0, 0, 4'b0000, 1, 4'b1101, "r27_done"));
    vq.push_back(v(0, 0, 4'b0000, 1, 4'b1100, "r27_done_low_se_idle"));
    // Word 0110 with SE pattern 1,0,0,1,1,1 after the load
    vq.push_back(v(0, 1, 4'b0110, 0, 4'b0010, "r28_b0"));
    vq.push_back(v(0, 0, 4'b0110, 1, 4'b0110, "r28_b1"));
    vq.push_back(v(0, 0, 4'b0110, 0, 4'b0110, "r28_hold1"));
    vq.push_back(v(0, 0, 4'b0110, 0, 4'b0110, "r28_hold2"));
    vq.push_back(v(0, 0, 4'b0110, 1, 4'b0110, "r28_b2"));
    vq.push_back(v(0, 0, 4'b0110, 1, 4'b0010, "r28_b3"));
    vq.push_back(v(0, 0, 4'b0110, 1, 4'b1101, "r28_done"));
    // LDV held high: 0001 then 1110, second loaded in the DONE cycle
    vq.push_back(v(0, 1, 4'b0001, 1, 4'b0110, "r29_a0"));
    vq.push_back(v(0, 1, 4'b0001, 1, 4'b0010, "r29_a1"));
    vq.push_back(v(0, 1, 4'b0001, 1, 4'b0010, "r29_a2"));
    vq.push_back(v(0, 1, 4'b0001, 1, 4'b0010, "r29_a3"));
    vq.push_back(v(0, 1, 4'b1110, 1, 4'b1101, "r29_done_a"));
    vq.push_back(v(0, 1, 4'b1110, 1, 4'b0010, "r29_b0"));
    vq.push_back(v(0, 0, 4'b1110, 1, 4'b0110, "r29_b1"));
    vq.push_back(v(0, 0, 4'b1110, 1, 4'b0110, "r29_b2"));
    vq.push_back(v(0, 0, 4'b1110, 1, 4'b0110, "r29_b3"));
    vq.push_back(v(0, 0, 4'b1110, 1, 4'b1101, "r29_done_b"));
    // Word 0000 with LDV=1 offering 1111 mid-frame
    vq.push_back(v(0, 1, 4'b0000, 1, 4'b0010, "r30_b0"));
    vq.push_back(v(0, 1, 4'b1111, 1, 4'b0010, "r30_b1"));
    vq.push_back(v(0, 1, 4'b1111, 1, 4'b0010, "r30_b2"));
    vq.push_back(v(0, 1, 4'b1111, 1, 4'b0010, "r30_b3"));
    vq.push_back(v(0, 0, 4'b1111, 1, 4'b1101, "r30_done"));
    vq.push_back(v(0, 0, 4'b1111, 1, 4'b1100, "r30_idle"));
    // CD overrides LDV/SE; first load on first edge with CD low; abort after second bit of 1010
    vq.push_back(v(1, 1, 4'b1111, 1, 4'b1100, "r23_cd_override"));
    vq.push_back(v(0, 1, 4'b1010, 1, 4'b0010, "r31_b0"));
    vq.push_back(v(0, 0, 4'b1010, 1, 4'b0110, "r31_b1"));
    vq.push_back(v(1, 0, 4'b1010, 1, 4'b1100, "r31_abort"));
    vq.push_back(v(0, 0, 4'b1010, 0, 4'b1100, "r31_no_done"));
    vq.push_back(v(0, 1, 4'b0101, 1, 4'b0110, "r31_c0"));
    vq.push_back(v(0, 0, 4'b0101, 1, 4'b0010, "r31_c1"));
    vq.push_back(v(0, 0, 4'b0101, 1, 4'b0110, "r31_c2"));
    vq.push_back(v(0, 0, 4'b0101, 1, 4'b0010, "r31_c3"));
    vq.push_back(v(0, 0, 4'b0101, 1, 4'b1101, "r31_done"));

    // Reset with the clock stopped
    #2;
    check("reset_no_clock", 4'b1100);
    clk_run = 1'b1;
    @(posedge CP);
    #1;
    CD = 1'b0;
    check("reset_released_idle", 4'b1100);

    foreach (vq[i]) begin
      drive(vq[i].cd, vq[i].ldv, vq[i].d, vq[i].se);
      @(posedge CP);
      #1;
      check(vq[i].name, vq[i].exp);
    end

    // Asynchronous abort mid-cycle: outputs must clear before the next edge
    drive(0, 1, 4'b1100, 1);
    @(posedge CP);
    #1;
    check("async_b0", 4'b0010);
    drive(0, 0, 4'b1100, 1);
    @(posedge CP);
    #1;
    check("async_b1", 4'b0010);
    #2;
    CD = 1'b1;
    #1;
    check("async_abort_between_edges", 4'b1100);
    @(posedge CP);
    #1;
    CD = 1'b0;
    check("async_held", 4'b1100);
    @(posedge CP);
    #1;
    check("async_no_done", 4'b1100);

    // Load in the DONE cycle back to back, SE pattern with holds at the end
    drive(0, 1, 4'b1000, 1);
    @(posedge CP); #1; check("bb_a0", 4'b0010);
    drive(0, 0, 4'b1000, 1);
    @(posedge CP); #1; check("bb_a1", 4'b0010);
    @(posedge CP); #1; check("bb_a2", 4'b0010);
    drive(0, 0, 4'b1000, 0);
    repeat (3) @(posedge CP);
    #1; check("bb_hold_a2", 4'b0010);
    drive(0, 0, 4'b1000, 1);
    @(posedge CP); #1; check("bb_a3", 4'b0110);
    drive(0, 1, 4'b0011, 1);
    @(posedge CP); #1; check("bb_done", 4'b1101);
    @(posedge CP); #1; check("bb_next_b0", 4'b0110);

    clk_run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
